// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator between the core data path and a
// word-wide data RAM with combinational read and synchronous write.
// Sub-word stores are done as read-modify-write. Misaligned or illegal
// requests complete with resp_err and never touch the RAM.
//
// Handshake: a request is accepted on a rising edge where
// req_valid && req_ready. req_ready is high only while idle, and req_valid is
// ignored at all other times. resp_valid is a one-cycle pulse that cannot be
// stalled. resp_err and resp_rdata are meaningful only while resp_valid is high.
module data_mem_lsu #(
    parameter int MEM_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [MEM_AW+1:0] addr_q;
    logic              err_q;
    // Store data after accept, merged word after READ, or the load result.
    logic [31:0]       data_q;

    logic              req_illegal;
    logic              req_misaligned;
    logic              req_bad;
    logic [1:0]        accept_next;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    // Address bits above the RAM window are dropped on purpose.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    // Decode the incoming request: legality, alignment, and first state.
    always_comb begin
        req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                         (req_we && req_funct3[2]);
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad        = req_illegal || req_misaligned;
        if (req_bad) begin
            accept_next = RESP;
        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
            accept_next = WRITE;
        end else begin
            accept_next = READ;
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3_q[1:0])
            2'b00:   load_val = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase

        merge_val = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_val[7:0]   = data_q[7:0];
                2'd1:    merge_val[15:8]  = data_q[7:0];
                2'd2:    merge_val[23:16] = data_q[7:0];
                default: merge_val[31:24] = data_q[7:0];
            endcase
        end else if (f3_q[1:0] == 2'b01) begin
            if (addr_q[1]) begin
                merge_val[31:16] = data_q[15:0];
            end else begin
                merge_val[15:0] = data_q[15:0];
            end
        end
    end

    // Request FSM: IDLE -> (READ) -> (WRITE) -> RESP -> IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            f3_q   <= 3'b000;
            addr_q <= '0;
            err_q  <= 1'b0;
            data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q   <= req_we;
                        f3_q   <= req_funct3;
                        addr_q <= req_addr[MEM_AW+1:0];
                        err_q  <= req_bad;
                        data_q <= (req_we && !req_bad) ? req_wdata : 32'h0;
                        state  <= accept_next;
                    end
                end
                READ: begin
                    data_q <= we_q ? merge_val : load_val;
                    state  <= we_q ? WRITE : RESP;
                end
                WRITE: begin
                    state <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; mem_we falls with reset because state does.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = ((state == RESP) && !we_q && !err_q) ? data_q : 32'h0;
        mem_we     = (state == WRITE);
        mem_wdata  = (state == WRITE) ? data_q : 32'h0;
        mem_addr   = addr_q[MEM_AW+1:2];
        fsm_state  = state;
    end

endmodule
